// File: rtl/cpu_defs.sv
// Shared CPU definitions for the TLB path: op encoding, index type, entry
// layout and the configured TLB size.
package cpu_defs;

    localparam int TLB_ENTRIES_NUM = 16;
    localparam int TLB_IDX_W       = $clog2(TLB_ENTRIES_NUM);

    // CP0 TLB instructions handled by the sequencer
    typedef enum logic [1:0] {
        TLBR  = 2'd0,
        TLBWI = 2'd1,
        TLBWR = 2'd2,
        TLBP  = 2'd3
    } tlb_op_t;

    typedef logic [TLB_IDX_W-1:0] tlb_index_t;

    // One TLB entry: EntryHi part (VPN2/ASID/G) plus the two EntryLo halves
    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    // Sequencer states; ST_CHECK is only reachable with the duplicate check
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_DONE  = 2'd2,
        ST_CHECK = 2'd3
    } tlb_ctrl_state_t;

    function automatic logic op_is_write(input tlb_op_t op);
        return (op == TLBWI) || (op == TLBWR);
    endfunction

    // EntryHi-format probe key built from an entry (bits 12:8 are zero)
    function automatic logic [31:0] entry_probe_key(input tlb_entry_t e);
        return {e.vpn2, 5'b0, e.asid};
    endfunction

endpackage

// File: rtl/tlb_random_gen.sv
// CP0 Random register: counts down from ENTRIES-1 to the Wired floor and
// wraps; a Wired write or an out-of-range Wired reloads ENTRIES-1.
module tlb_random_gen
    import cpu_defs::*;
#(
    parameter int ENTRIES = TLB_ENTRIES_NUM,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      cp0_wired,
    input  logic             wired_we,
    output logic [IDX_W-1:0] random
);

    localparam logic [IDX_W-1:0] RANDOM_MAX = IDX_W'(ENTRIES - 1);

    logic [IDX_W-1:0] random_reg;
    logic [IDX_W-1:0] random_next;
    logic             wired_out_of_range;

    // Next Random value: reload on Wired write, oversize Wired, or at the floor
    always_comb begin
        random_next        = random_reg - 1'b1;
        wired_out_of_range = (cp0_wired >= 32'(ENTRIES));
        if (wired_we || wired_out_of_range || (random_reg <= cp0_wired[IDX_W-1:0])) begin
            random_next = RANDOM_MAX;
        end
    end

    // Random state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            random_reg <= RANDOM_MAX;
        end else begin
            random_reg <= random_next;
        end
    end

    assign random = random_reg;

endmodule

// File: rtl/tlb_op_ctrl.sv
// TLB instruction sequencer (TLBR/TLBWI/TLBWR/TLBP) between CP0 and the
// shared TLB array. Optional macro TLB_OP_CTRL_DUP_CHECK_EN inserts a probe
// of the write entry before TLBWI/TLBWR and suppresses duplicate writes.
module tlb_op_ctrl
    import cpu_defs::*;
#(
    parameter int ENTRIES = TLB_ENTRIES_NUM,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  tlb_op_t          req_op,
    output logic             req_ready,
    input  logic [31:0]      cp0_index,
    input  logic [31:0]      cp0_entry_hi,
    input  logic [31:0]      cp0_wired,
    input  logic             wired_we,
    input  tlb_entry_t       wr_entry,
    output logic             done_valid,
    output tlb_op_t          done_op,
    output tlb_entry_t       rd_entry,
    output logic [31:0]      probe_index,
    output logic             dup_err,
    output logic [31:0]      random_out,
    output logic [IDX_W-1:0] tlbrw_index,
    output logic             tlbrw_we,
    output tlb_entry_t       tlbrw_wdata,
    input  tlb_entry_t       tlbrw_rdata,
    output logic [31:0]      tlbp_entry_hi,
    input  logic [31:0]      tlbp_index
);

    tlb_ctrl_state_t  state_reg;
    tlb_op_t          op_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [31:0]      entry_hi_reg;
    tlb_entry_t       wr_entry_reg;
    tlb_entry_t       rd_entry_reg;
    logic [31:0]      probe_index_reg;
    logic             done_valid_reg;
    tlb_op_t          done_op_reg;
    logic [IDX_W-1:0] random_idx;
    logic             unused_index_bits;

    // Only the low IDX_W bits of CP0 Index select an entry
    assign unused_index_bits = ^cp0_index[31:IDX_W];

    tlb_random_gen #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W)
    ) u_random (
        .clk       (clk),
        .rst_n     (rst_n),
        .cp0_wired (cp0_wired),
        .wired_we  (wired_we),
        .random    (random_idx)
    );

`ifdef TLB_OP_CTRL_DUP_CHECK_EN
    logic dup_reg;
    logic dup_err_reg;

    // Sequencer FSM with duplicate-entry check ahead of writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            op_reg          <= TLBR;
            idx_reg         <= '0;
            entry_hi_reg    <= '0;
            wr_entry_reg    <= '0;
            rd_entry_reg    <= '0;
            probe_index_reg <= '0;
            done_valid_reg  <= 1'b0;
            done_op_reg     <= TLBR;
            dup_reg         <= 1'b0;
            dup_err_reg     <= 1'b0;
        end else begin
            done_valid_reg <= 1'b0;
            dup_err_reg    <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_reg       <= req_op;
                        idx_reg      <= (req_op == TLBWR) ? random_idx : cp0_index[IDX_W-1:0];
                        entry_hi_reg <= cp0_entry_hi;
                        wr_entry_reg <= wr_entry;
                        dup_reg      <= 1'b0;
                        state_reg    <= op_is_write(req_op) ? ST_CHECK : ST_EXEC;
                    end
                end
                ST_CHECK: begin
                    // A hit somewhere other than the target would create a duplicate
                    dup_reg   <= !tlbp_index[31] && (tlbp_index[IDX_W-1:0] != idx_reg);
                    state_reg <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (op_reg == TLBR) rd_entry_reg <= tlbrw_rdata;
                    if (op_reg == TLBP) probe_index_reg <= tlbp_index;
                    done_valid_reg <= 1'b1;
                    done_op_reg    <= op_reg;
                    dup_err_reg    <= dup_reg;
                    state_reg      <= ST_DONE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign tlbrw_we      = (state_reg == ST_EXEC) && op_is_write(op_reg) && !dup_reg;
    assign tlbp_entry_hi = (state_reg == ST_CHECK) ? entry_probe_key(wr_entry_reg) : entry_hi_reg;
    assign dup_err       = dup_err_reg;
`else
    // Sequencer FSM: accept, one array-access cycle, one done cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            op_reg          <= TLBR;
            idx_reg         <= '0;
            entry_hi_reg    <= '0;
            wr_entry_reg    <= '0;
            rd_entry_reg    <= '0;
            probe_index_reg <= '0;
            done_valid_reg  <= 1'b0;
            done_op_reg     <= TLBR;
        end else begin
            done_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_reg       <= req_op;
                        idx_reg      <= (req_op == TLBWR) ? random_idx : cp0_index[IDX_W-1:0];
                        entry_hi_reg <= cp0_entry_hi;
                        wr_entry_reg <= wr_entry;
                        state_reg    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (op_reg == TLBR) rd_entry_reg <= tlbrw_rdata;
                    if (op_reg == TLBP) probe_index_reg <= tlbp_index;
                    done_valid_reg <= 1'b1;
                    done_op_reg    <= op_reg;
                    state_reg      <= ST_DONE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign tlbrw_we      = (state_reg == ST_EXEC) && op_is_write(op_reg);
    assign tlbp_entry_hi = entry_hi_reg;
    assign dup_err       = 1'b0;
`endif

    assign req_ready   = (state_reg == ST_IDLE);
    assign done_valid  = done_valid_reg;
    assign done_op     = done_op_reg;
    assign rd_entry    = rd_entry_reg;
    assign probe_index = probe_index_reg;
    assign random_out  = {{(32-IDX_W){1'b0}}, random_idx};
    assign tlbrw_index = idx_reg;
    assign tlbrw_wdata = wr_entry_reg;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Self-checking bench for tlb_op_ctrl: emulates the TLB array, keeps a
// reference TLB image and a Random model, drives directed and random ops.
module tb_tlb_op_ctrl;
    import cpu_defs::*;

    localparam int N  = TLB_ENTRIES_NUM;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    tlb_op_t       req_op = TLBR;
    logic          req_ready;
    logic [31:0]   cp0_index = '0;
    logic [31:0]   cp0_entry_hi = '0;
    logic [31:0]   cp0_wired = '0;
    logic          wired_we = 1'b0;
    tlb_entry_t    wr_entry = '0;
    logic          done_valid;
    tlb_op_t       done_op;
    tlb_entry_t    rd_entry;
    logic [31:0]   probe_index;
    logic          dup_err;
    logic [31:0]   random_out;
    logic [IW-1:0] tlbrw_index;
    logic          tlbrw_we;
    tlb_entry_t    tlbrw_wdata;
    tlb_entry_t    tlbrw_rdata;
    logic [31:0]   tlbp_entry_hi;
    logic [31:0]   tlbp_index;

    int n_checks = 0;
    int n_pass   = 0;
    int rand_m;
    logic rand_en = 1'b0;

    tlb_entry_t mem[N];
    tlb_entry_t ref_mem[N];
    tlb_entry_t last_rd = '0;
    logic [31:0] last_probe = '0;

    always #5 clk = ~clk;

    tlb_op_ctrl #(.ENTRIES(N), .IDX_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
        .req_ready(req_ready), .cp0_index(cp0_index), .cp0_entry_hi(cp0_entry_hi),
        .cp0_wired(cp0_wired), .wired_we(wired_we), .wr_entry(wr_entry),
        .done_valid(done_valid), .done_op(done_op), .rd_entry(rd_entry),
        .probe_index(probe_index), .dup_err(dup_err), .random_out(random_out),
        .tlbrw_index(tlbrw_index), .tlbrw_we(tlbrw_we), .tlbrw_wdata(tlbrw_wdata),
        .tlbrw_rdata(tlbrw_rdata), .tlbp_entry_hi(tlbp_entry_hi), .tlbp_index(tlbp_index)
    );

    function automatic logic key_match(input tlb_entry_t e, input logic [31:0] key);
        return (e.vpn2 == key[31:13]) && (e.g || (e.asid == key[7:0]));
    endfunction

    // Emulated TLB array: synchronous write, combinational read and probe
    always @(posedge clk) if (tlbrw_we) mem[tlbrw_index] <= tlbrw_wdata;

    always_comb begin
        tlbrw_rdata = mem[tlbrw_index];
        tlbp_index  = 32'h8000_0000;
        for (int i = N - 1; i >= 0; i--)
            if (key_match(mem[i], tlbp_entry_hi)) tlbp_index = 32'(i);
    end

    // Reference Random: counts down from N-1 to the Wired floor, then reloads
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rand_m <= N - 1;
        else if (wired_we || cp0_wired >= 32'(N) || 32'(rand_m) <= cp0_wired) rand_m <= N - 1;
        else rand_m <= rand_m - 1;
    end

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", tag, act, exp);
        else n_pass++;
    endtask

    always @(negedge clk) if (rst_n) check("random_track", 128'(random_out), 128'(rand_m));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Occasional Wired writes during random traffic
    initial forever begin
        @(posedge clk);
        #1;
        if (rand_en) wired_we = ($urandom_range(0, 9) == 0);
    end

    function automatic logic [31:0] ref_probe(input logic [31:0] key);
        for (int i = 0; i < N; i++)
            if (key_match(ref_mem[i], key)) return 32'(i);
        return 32'h8000_0000;
    endfunction

    function automatic tlb_entry_t make_entry(input int vpn);
        tlb_entry_t e;
        e.vpn2 = 19'(vpn);
        e.asid = 8'($urandom_range(0, 3));
        e.g    = 1'($urandom_range(0, 1));
        e.pfn0 = 20'($urandom);
        e.c0   = 3'($urandom_range(0, 7));
        e.d0   = 1'($urandom_range(0, 1));
        e.v0   = 1'($urandom_range(0, 1));
        e.pfn1 = 20'($urandom);
        e.c1   = 3'($urandom_range(0, 7));
        e.d1   = 1'($urandom_range(0, 1));
        e.v1   = 1'($urandom_range(0, 1));
        return e;
    endfunction

    task automatic do_op(input tlb_op_t op, input logic [31:0] idx, input tlb_entry_t e,
                         input logic [31:0] eh);
        int w;
        logic [IW-1:0] tgt;
        logic is_wr, dup;
        tlb_entry_t exp_rd;
        logic [31:0] exp_probe, hit;
        w = 0;
        while (!req_ready && w < 20) begin tick(); w++; end
        check("ready_wait", 128'(req_ready), 128'(1));
        check("rd_hold", 128'(rd_entry), 128'(last_rd));
        check("probe_hold", 128'(probe_index), 128'(last_probe));
        req_valid = 1'b1; req_op = op; cp0_index = idx; cp0_entry_hi = eh; wr_entry = e;
        is_wr = (op == TLBWI) || (op == TLBWR);
        tgt = (op == TLBWR) ? IW'(rand_m) : idx[IW-1:0];
        dup = 1'b0;
`ifdef TLB_OP_CTRL_DUP_CHECK_EN
        if (is_wr) begin
            hit = ref_probe({e.vpn2, 5'b0, e.asid});
            dup = !hit[31] && (hit[IW-1:0] != tgt);
        end
`else
        hit = 32'h8000_0000;
`endif
        exp_probe = ref_probe(eh);
        $display("txn op=%0d idx=%0d vpn2=%h dup=%0d hit=%h", op, tgt, e.vpn2, dup, hit);
        tick();
        req_valid = 1'b0;
`ifdef TLB_OP_CTRL_DUP_CHECK_EN
        if (is_wr) begin
            check("check_ready", 128'(req_ready), 128'(0));
            check("check_we", 128'(tlbrw_we), 128'(0));
            check("check_key", 128'(tlbp_entry_hi), 128'({e.vpn2, 5'b0, e.asid}));
            tick();
        end
`endif
        check("exec_ready", 128'(req_ready), 128'(0));
        check("exec_we", 128'(tlbrw_we), 128'(is_wr && !dup));
        check("exec_done", 128'(done_valid), 128'(0));
        if (is_wr) begin
            check("wr_index", 128'(tlbrw_index), 128'(tgt));
            check("wr_data", 128'(tlbrw_wdata), 128'(e));
            if (!dup) ref_mem[tgt] = e;
        end
        if (op == TLBR) check("rd_index", 128'(tlbrw_index), 128'(tgt));
        if (op == TLBP) check("probe_key", 128'(tlbp_entry_hi), 128'(eh));
        exp_rd = ref_mem[tgt];
        tick();
        check("done_valid", 128'(done_valid), 128'(1));
        check("done_op", 128'(done_op), 128'(op));
        check("dup_err", 128'(dup_err), 128'(dup));
        check("done_ready", 128'(req_ready), 128'(0));
        if (op == TLBR) begin
            check("rd_entry", 128'(rd_entry), 128'(exp_rd));
            last_rd = exp_rd;
        end
        if (op == TLBP) begin
            check("probe_index", 128'(probe_index), 128'(exp_probe));
            last_probe = exp_probe;
        end
        tick();
        check("done_drop", 128'(done_valid), 128'(0));
        check("idle_ready", 128'(req_ready), 128'(1));
    endtask

    initial begin
        tlb_entry_t e5, e;
        logic [31:0] key5;
        tlb_op_t op;
        logic [IW-1:0] tgt;
        int w;

        // Reset state
        tick(); tick();
        check("rst_ready", 128'(req_ready), 128'(1));
        check("rst_done", 128'(done_valid), 128'(0));
        check("rst_done_op", 128'(done_op), 128'(0));
        check("rst_rd_entry", 128'(rd_entry), 128'(0));
        check("rst_probe", 128'(probe_index), 128'(0));
        check("rst_dup", 128'(dup_err), 128'(0));
        check("rst_random", 128'(random_out), 128'(N - 1));
        check("rst_we", 128'(tlbrw_we), 128'(0));
        check("rst_index", 128'(tlbrw_index), 128'(0));
        check("rst_wdata", 128'(tlbrw_wdata), 128'(0));
        check("rst_probe_key", 128'(tlbp_entry_hi), 128'(0));
        rst_n = 1'b1;

        // Free-running Random with Wired=0, then Wired=3
        for (int i = 0; i < 34; i++) tick();
        cp0_wired = 32'd3;
        for (int i = 0; i < 30; i++) tick();

        // Wired beyond the TLB size pins Random at the top
        cp0_wired = 32'd20;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("wired_big_hold", 128'(random_out), 128'(N - 1));
        end

        // Wired write while Random is 7 reloads the top value
        cp0_wired = 32'd2;
        w = 0;
        while (random_out != 32'd7 && w < 40) begin tick(); w++; end
        check("reach_seven", 128'(random_out), 128'(7));
        wired_we = 1'b1;
        tick();
        wired_we = 1'b0;
        check("wired_we_reload", 128'(random_out), 128'(N - 1));

        // Fill the array with distinct entries
        for (int i = 0; i < N; i++) do_op(TLBWI, 32'(i), make_entry(32'h100 + i), 32'h0);

        // Directed write/read/probe of entry 5
        e5 = make_entry(32'h555);
        key5 = {e5.vpn2, 5'b0, e5.asid};
        do_op(TLBWI, 32'h0000_0005, e5, 32'h0);
        do_op(TLBR, 32'hFFFF_FFF5, '0, 32'h0);
        do_op(TLBP, 32'h0, '0, key5);
        check("probe_hit5", 128'(last_probe), 128'(32'h5));
        do_op(TLBP, 32'h0, '0, 32'h7777_E000);
        check("probe_miss", 128'(last_probe), 128'(32'h8000_0000));

        // Write at index 2 an entry already present at index 9
        do_op(TLBWI, 32'd2, ref_mem[9], 32'h0);

        // Held request is accepted only every third cycle
        req_valid = 1'b1; req_op = TLBP; cp0_entry_hi = key5;
        for (int k = 0; k < 9; k++) begin
            check("b2b_ready", 128'(req_ready), 128'(k % 3 == 0));
            check("b2b_done", 128'(done_valid), 128'(k % 3 == 2));
            tick();
        end
        req_valid = 1'b0;
        last_probe = ref_probe(key5);

        // Random traffic with live Wired changes
        rand_en = 1'b1;
        for (int t = 0; t < 40; t++) begin
            cp0_wired = 32'($urandom_range(0, 4));
            op = tlb_op_t'($urandom_range(0, 3));
            e = make_entry(32'h100 + $urandom_range(0, 15));
            do_op(op, $urandom, e, {e.vpn2, 5'($urandom), 8'($urandom_range(0, 3))});
        end
        rand_en = 1'b0;
        wired_we = 1'b0;
        tick();

        // Reset during the write cycle of a TLBWR
        e = make_entry(32'h7AB);
        req_valid = 1'b1; req_op = TLBWR; wr_entry = e;
        tgt = IW'(rand_m);
        tick();
        req_valid = 1'b0;
`ifdef TLB_OP_CTRL_DUP_CHECK_EN
        tick();
`endif
        check("abort_we_before", 128'(tlbrw_we), 128'(1));
        rst_n = 1'b0;
        #1;
        check("abort_we_drop", 128'(tlbrw_we), 128'(0));
        check("abort_ready", 128'(req_ready), 128'(1));
        tick();
        check("abort_no_done", 128'(done_valid), 128'(0));
        check("abort_no_write", 128'(mem[tgt]), 128'(ref_mem[tgt]));
        tick();
        rst_n = 1'b1;
        check("abort_ready_after", 128'(req_ready), 128'(1));
        check("abort_random", 128'(random_out), 128'(N - 1));
        last_rd = '0;
        last_probe = '0;
        do_op(TLBR, {28'h0, 4'(tgt)}, '0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
